// File: rtl/stream_harness_router_pkg.sv
// Shared defaults and helpers for the stream harness router.
// Holds the deserialiser beat-count helper and the saturating stats counter type.
package stream_harness_pkg;

  localparam int unsigned DefNcode = 8;
  localparam int unsigned DefNdata = 24;
  localparam int unsigned DefNch   = 2;
  localparam int unsigned DefNdown = 34;
  localparam int unsigned DefNup   = 21;
  localparam int unsigned StatW    = 16;

  typedef logic [StatW-1:0] stat_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic stat_t sat_inc(input stat_t cnt, input logic en);
    return (en && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

endpackage

// File: rtl/stream_harness_router_if.sv
// Valid/ready word channel used for the PC and core links of the router.
interface stream_harness_router_if #(
  parameter int unsigned W = stream_harness_pkg::DefNcode + stream_harness_pkg::DefNdata
);
  logic [W-1:0] d;
  logic         v;
  logic         a;

  modport master (output d, output v, input a);
  modport slave  (input d, input v, output a);
endinterface

// File: rtl/stream_harness_router_deser.sv
// Per-channel deserialiser: gathers ceil(NDOWN/NDATA) payload beats into one output word.
// The final beat loads the output register directly, so a drained register never costs a cycle.
module stream_deser
  import stream_harness_pkg::*;
#(
  parameter int unsigned NDATA = DefNdata,
  parameter int unsigned NDOWN = DefNdown
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NDATA-1:0] in_d_i,
  input  logic             in_v_i,
  output logic             in_a_o,
  output logic [NDOWN-1:0] out_d_o,
  output logic             out_v_o,
  input  logic             out_a_i
);

  localparam int unsigned K    = ceil_div(NDOWN, NDATA);
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned AccW = K * NDATA;
  localparam logic [CntW-1:0] LastBeat = CntW'(K - 1);

  logic [CntW-1:0]  beat_q, beat_d;
  logic [AccW-1:0]  acc_q, acc_d, acc_full;
  logic [NDOWN-1:0] dat_q, dat_d;
  logic             out_v_q, out_v_d;
  logic             is_last, xfer;

  assign is_last = (beat_q == LastBeat);
  assign in_a_o  = !is_last || !out_v_q || out_a_i;
  assign xfer    = in_v_i && in_a_o;

  always_comb begin
    acc_full = acc_q;
    acc_full[beat_q*NDATA +: NDATA] = in_d_i;

    beat_d  = beat_q;
    acc_d   = acc_q;
    dat_d   = dat_q;
    out_v_d = out_v_q;
    if (out_v_q && out_a_i) begin
      out_v_d = 1'b0;
    end
    if (xfer) begin
      if (is_last) begin
        // Bits of the final beat beyond NDOWN are dropped here.
        dat_d   = acc_full[NDOWN-1:0];
        out_v_d = 1'b1;
        beat_d  = '0;
      end else begin
        acc_d  = acc_full;
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      acc_q   <= '0;
      dat_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      dat_q   <= dat_d;
      out_v_q <= out_v_d;
    end
  end

  assign out_d_o = dat_q;
  assign out_v_o = out_v_q;

endmodule

// File: rtl/stream_harness_router.sv
// PC-side traffic router: splits PC words to per-channel deserialisers or the core, and merges
// tagged endpoint words with core traffic round-robin. STREAM_STATS_EN adds the stats_d port.
module stream_harness_router
  import stream_harness_pkg::*;
#(
  parameter int unsigned NCODE = DefNcode,
  parameter int unsigned NDATA = DefNdata,
  parameter int unsigned NCH   = DefNch,
  parameter int unsigned NDOWN = DefNdown,
  parameter int unsigned NUP   = DefNup,
  parameter logic [NCH*NCODE-1:0] CODES = {8'hFE, 8'hFF}
) (
  input  logic                   clk,
  input  logic                   reset,
  stream_harness_router_if.slave  PC_in,
  stream_harness_router_if.master PC_out,
  stream_harness_router_if.master core_PC_in,
  stream_harness_router_if.slave  core_PC_out,
  output logic [NCH*NDOWN-1:0]   down_d,
  output logic [NCH-1:0]         down_v,
  input  logic [NCH-1:0]         down_a,
  input  logic [NCH*NUP-1:0]     up_d,
  input  logic [NCH-1:0]         up_v,
  output logic [NCH-1:0]         up_a
`ifdef STREAM_STATS_EN
  ,
  output logic [(2*NCH+1)*StatW-1:0] stats_d
`endif
);

  localparam int unsigned W    = NCODE + NDATA;
  localparam int unsigned NSRC = NCH + 1;
  localparam int unsigned PtrW = $clog2(NSRC);

  // ---------------------------------------------------------------- split
  logic [NCODE-1:0] code;
  logic [NCH-1:0]   match, beat_v, beat_a;
  logic             any_match;

  always_comb begin
    code  = PC_in.d[W-1 -: NCODE];
    match = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      match[i] = (code == CODES[i*NCODE +: NCODE]);
    end
  end

  assign any_match    = |match;
  assign beat_v       = match & {NCH{PC_in.v}};
  assign core_PC_in.d = PC_in.d;
  assign core_PC_in.v = PC_in.v && !any_match;
  assign PC_in.a      = any_match ? |(match & beat_a) : core_PC_in.a;

  for (genvar g = 0; g < NCH; g++) begin : gen_deser
    stream_deser #(
      .NDATA (NDATA),
      .NDOWN (NDOWN)
    ) u_deser (
      .clk_i   (clk),
      .rst_ni  (reset),
      .in_d_i  (PC_in.d[NDATA-1:0]),
      .in_v_i  (beat_v[g]),
      .in_a_o  (beat_a[g]),
      .out_d_o (down_d[g*NDOWN +: NDOWN]),
      .out_v_o (down_v[g]),
      .out_a_i (down_a[g])
    );
  end

  // ---------------------------------------------------------------- merge
  logic [W-1:0]    src_d [NSRC];
  logic [NSRC-1:0] src_v, src_a;
  logic [PtrW-1:0] ptr_q, ptr_d, win, idx;
  logic [W-1:0]    out_dat_q, out_dat_d;
  logic            out_v_q, out_v_d;
  logic            found, load, grant;

  function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NSRC) s = s - NSRC;
    return PtrW'(s);
  endfunction

  always_comb begin
    src_v[0] = core_PC_out.v;
    src_d[0] = core_PC_out.d;
    for (int unsigned i = 0; i < NCH; i++) begin
      src_v[i+1] = up_v[i];
      src_d[i+1] = {CODES[i*NCODE +: NCODE], NDATA'(up_d[i*NUP +: NUP])};
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    // First requester at or after the pointer, wrapping round.
    for (int unsigned off = 0; off < NSRC; off++) begin
      idx = wrap_idx(ptr_q, off);
      if (!found && src_v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    load  = !out_v_q || PC_out.a;
    grant = found && load;

    src_a = '0;
    if (grant) src_a[win] = 1'b1;

    ptr_d     = ptr_q;
    out_dat_d = out_dat_q;
    out_v_d   = out_v_q;
    if (grant) begin
      out_dat_d = src_d[win];
      out_v_d   = 1'b1;
      ptr_d     = (win == PtrW'(NSRC - 1)) ? '0 : win + 1'b1;
    end else if (PC_out.a) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      out_dat_q <= '0;
      out_v_q   <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      out_dat_q <= out_dat_d;
      out_v_q   <= out_v_d;
    end
  end

  assign core_PC_out.a = src_a[0];
  assign up_a          = src_a[NSRC-1:1];
  assign PC_out.d      = out_dat_q;
  assign PC_out.v      = out_v_q;

`ifdef STREAM_STATS_EN
  // ---------------------------------------------------------------- stats
  stat_t down_cnt_q [NCH];
  stat_t up_cnt_q   [NCH];
  stat_t pass_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        down_cnt_q[i] <= '0;
        up_cnt_q[i]   <= '0;
      end
      pass_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        down_cnt_q[i] <= sat_inc(down_cnt_q[i], down_v[i] && down_a[i]);
        up_cnt_q[i]   <= sat_inc(up_cnt_q[i], src_a[i+1]);
      end
      pass_cnt_q <= sat_inc(pass_cnt_q, core_PC_in.v && core_PC_in.a);
    end
  end

  always_comb begin
    stats_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      stats_d[i*StatW +: StatW]       = down_cnt_q[i];
      stats_d[(NCH+i)*StatW +: StatW] = up_cnt_q[i];
    end
    stats_d[2*NCH*StatW +: StatW] = pass_cnt_q;
  end
`endif

endmodule

// File: tb/tb_stream_harness_router.sv
// Directed bench for stream_harness_router with default parameters (channel 0 = FF, 1 = FE).
module tb_stream_harness_router;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [67:0] down_d;
  logic [1:0]  down_v, down_a, up_v, up_a;
  logic [41:0] up_d;
`ifdef STREAM_STATS_EN
  logic [79:0] stats_d;
`endif

  always #5 clk = ~clk;

  stream_harness_router_if #(.W(32)) pc_in ();
  stream_harness_router_if #(.W(32)) pc_out ();
  stream_harness_router_if #(.W(32)) core_in ();
  stream_harness_router_if #(.W(32)) core_out ();

  stream_harness_router dut (
    .clk         (clk),
    .reset       (reset),
    .PC_in       (pc_in),
    .PC_out      (pc_out),
    .core_PC_in  (core_in),
    .core_PC_out (core_out),
    .down_d      (down_d),
    .down_v      (down_v),
    .down_a      (down_a),
    .up_d        (up_d),
    .up_v        (up_v),
    .up_a        (up_a)
`ifdef STREAM_STATS_EN
    ,
    .stats_d     (stats_d)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic        v;
    logic        core_a;
    logic        exp_v;
    logic        exp_a;
  } vec_t;

  vec_t        vecs [7];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one PC word and wait (bounded) for it to be accepted.
  task automatic send_pc(input string name, input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    pc_in.d = w;
    pc_in.v = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = pc_in.a;
      tick();
    end
    pc_in.v = 1'b0;
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: word %0h not accepted within 20 cycles", name, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] gnt, exp_gnt;
    int         order [6];

    pc_in.d = '0;
    pc_in.v = 1'b0;
    core_in.a = 1'b1;
    core_out.d = '0;
    core_out.v = 1'b0;
    pc_out.a = 1'b0;
    down_a = '0;
    up_v = '0;
    up_d = '0;

    // Reset state
    tick();
    tick();
    check("rst_pc_out_v", 64'(pc_out.v), 64'd0);
    check("rst_pc_out_d", 64'(pc_out.d), 64'd0);
    check("rst_down_v", 64'(down_v), 64'd0);
    check("rst_down_d0", 64'(down_d[33:0]), 64'd0);
    check("rst_down_d1", 64'(down_d[67:34]), 64'd0);
    #2 reset = 1'b1;
    tick();

    // Combinational split vectors: d, v, core_a -> core_in.v, pc_in.a
    vecs[0] = '{32'h01ABCDEF, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{32'h01ABCDEF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'hFF123456, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'hFE000001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'hFD000000, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{32'hFEFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      tick();
      pc_in.d = vecs[i].d;
      pc_in.v = vecs[i].v;
      core_in.a = vecs[i].core_a;
      #1;
      check($sformatf("vec%0d_core_v", i), 64'(core_in.v), 64'(vecs[i].exp_v));
      check($sformatf("vec%0d_pc_a", i), 64'(pc_in.a), 64'(vecs[i].exp_a));
      check($sformatf("vec%0d_core_d", i), 64'(core_in.d), 64'(vecs[i].d));
      pc_in.v = 1'b0;
    end
    core_in.a = 1'b1;
    tick();
    check("split_no_down_v", 64'(down_v), 64'd0);

    // Two-beat deserialise on channel 0
    send_pc("deser_b0", 32'hFF123456);
    check("deser_mid_v", 64'(down_v), 64'd0);
    send_pc("deser_b1", 32'hFF0003FF);
    check("deser_v", 64'(down_v), 64'd1);
    check("deser_d0", 64'(down_d[33:0]), 64'h3FF123456);
    check("deser_d1", 64'(down_d[67:34]), 64'd0);
    tick();
    check("deser_hold_d0", 64'(down_d[33:0]), 64'h3FF123456);
    check("deser_hold_v", 64'(down_v), 64'd1);
    down_a[0] = 1'b1;
    tick();
    down_a[0] = 1'b0;
    check("deser_drain_v", 64'(down_v), 64'd0);

    // Stall: four beats with down_a[0] low
    send_pc("stall_b0", 32'hFF000001);
    send_pc("stall_b1", 32'hFF000002);
    check("stall_first_v", 64'(down_v), 64'd1);
    check("stall_first_d", 64'(down_d[33:0]), 64'h002000001);
    send_pc("stall_b2", 32'hFF0000AA);
    pc_in.d = 32'hFF000155;
    pc_in.v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_a_low%0d", i), 64'(pc_in.a), 64'd0);
      check($sformatf("stall_hold_d%0d", i), 64'(down_d[33:0]), 64'h002000001);
      tick();
    end
    down_a[0] = 1'b1;
    #1;
    check("stall_release_a", 64'(pc_in.a), 64'd1);
    tick();
    pc_in.v = 1'b0;
    check("stall_second_v", 64'(down_v), 64'd1);
    check("stall_second_d", 64'(down_d[33:0]), 64'h1550000AA);
    tick();
    down_a[0] = 1'b0;
    check("stall_drained_v", 64'(down_v), 64'd0);

    // Merge tagging
    pc_out.a = 1'b1;
    up_d[20:0] = 21'h1FFFFF;
    up_v = 2'b01;
    #1;
    check("merge0_up_a", 64'(up_a), 64'd1);
    tick();
    up_v = 2'b00;
    check("merge0_v", 64'(pc_out.v), 64'd1);
    check("merge0_d", 64'(pc_out.d), 64'hFF1FFFFF);
    up_d[41:21] = 21'h000ABC;
    up_v = 2'b10;
    #1;
    check("merge1_up_a", 64'(up_a), 64'd2);
    tick();
    up_v = 2'b00;
    check("merge1_d", 64'(pc_out.d), 64'hFE000ABC);

    // Back-pressure on PC_out holds the word
    pc_out.a = 1'b0;
    core_out.d = 32'h12345678;
    core_out.v = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("hold_core_a%0d", i), 64'(core_out.a), 64'd0);
      tick();
      check($sformatf("hold_d%0d", i), 64'(pc_out.d), 64'hFE000ABC);
      check($sformatf("hold_v%0d", i), 64'(pc_out.v), 64'd1);
    end
    pc_out.a = 1'b1;
    #1;
    check("hold_release_a", 64'(core_out.a), 64'd1);
    tick();
    core_out.v = 1'b0;
    check("hold_core_d", 64'(pc_out.d), 64'h12345678);
    tick();
    check("idle_v", 64'(pc_out.v), 64'd0);

    // Reset so the pointer starts at 0, then all sources request
    reset = 1'b0;
    #1;
    check("rst2_pc_out_v", 64'(pc_out.v), 64'd0);
    #1 reset = 1'b1;
    tick();
    order = '{0, 1, 2, 0, 1, 2};
    core_out.d = 32'hAAAAAAAA;
    core_out.v = 1'b1;
    up_d = {21'h000002, 21'h000001};
    up_v = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      gnt = {up_a, core_out.a};
      exp_gnt = 3'b001 << order[i];
      check($sformatf("fair_grant%0d", i), 64'(gnt), 64'(exp_gnt));
      tick();
    end
    check("fair_last_d", 64'(pc_out.d), 64'hFE000002);
    core_out.v = 1'b0;
    up_v = 2'b00;
    tick();

    // Reset mid-message discards the partial beat
    send_pc("rmid_b0", 32'hFF000077);
    #1 reset = 1'b0;
    #1;
    check("rmid_down_v", 64'(down_v), 64'd0);
    #1 reset = 1'b1;
    tick();
    send_pc("rmid_n0", 32'hFF111111);
    check("rmid_partial_v", 64'(down_v), 64'd0);
    send_pc("rmid_n1", 32'hFF000222);
    check("rmid_v", 64'(down_v), 64'd1);
    check("rmid_d", 64'(down_d[33:0]), 64'h222111111);
    down_a[0] = 1'b1;
    tick();
    down_a[0] = 1'b0;
    check("rmid_drained_v", 64'(down_v), 64'd0);
`ifdef STREAM_STATS_EN
    check("rmid_stats_down0", 64'(stats_d[15:0]), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
